// File: rtl/sdram_rd_arbiter.sv
// rtl/sdram_rd_arbiter.sv - two-master round-robin burst arbiter for a shared AXI-style read port
module sdram_rd_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int BURST = 32,
    parameter int CW    = $clog2(BURST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] araddr_0,
    input  logic [AW-1:0] araddr_1,
    input  logic [1:0]    arburst_0,
    input  logic [1:0]    arburst_1,
    input  logic          arvalid_0,
    input  logic          arvalid_1,
    output logic          arready_0,
    output logic          arready_1,
    output logic [DW-1:0] rdata_0,
    output logic [DW-1:0] rdata_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic          rlast_0,
    output logic          rlast_1,
    output logic [AW-1:0] araddr_s,
    output logic [1:0]    arburst_s,
    output logic          arvalid_s,
    input  logic          arready_s,
    input  logic [DW-1:0] rdata_s,
    input  logic          rvalid_s,
    input  logic          rlast_s,
    output logic          grant,
    output logic          busy,
    output logic          len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          len_err_q, len_err_d;

    // One extra bit so the beat number never wraps, whatever BURST is.
    logic [CW:0]   beat_num;
    assign beat_num = {1'b0, cnt_q} + (CW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        case (state_q)
            S_IDLE: begin
                if (arvalid_0 | arvalid_1) begin
                    grant_d = (arvalid_0 & arvalid_1) ? prio_q : arvalid_1;
                    state_d = S_ADDR;
                end
                if (rvalid_s) len_err_d = 1'b1;
            end
            S_ADDR: begin
                if (arready_s) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
                if (rvalid_s) len_err_d = 1'b1;
            end
            S_DATA: begin
                if (rvalid_s) begin
                    if (cnt_q != CW'(BURST)) cnt_d = beat_num[CW-1:0];
                    if (rlast_s) begin
                        if (beat_num != (CW+1)'(BURST)) len_err_d = 1'b1;
                        prio_d  = ~grant_q;
                        state_d = S_IDLE;
                    end else if (beat_num >= (CW+1)'(BURST)) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic in_addr, in_data;
    assign in_addr = (state_q == S_ADDR);
    assign in_data = (state_q == S_DATA);

    assign araddr_s  = grant_q ? araddr_1  : araddr_0;
    assign arburst_s = grant_q ? arburst_1 : arburst_0;
    assign arvalid_s = in_addr;
    assign arready_0 = in_addr & ~grant_q & arready_s;
    assign arready_1 = in_addr &  grant_q & arready_s;

    // Read data fans out unconditionally; only the qualifiers are routed.
    assign rdata_0  = rdata_s;
    assign rdata_1  = rdata_s;
    assign rvalid_0 = in_data & ~grant_q & rvalid_s;
    assign rvalid_1 = in_data &  grant_q & rvalid_s;
    assign rlast_0  = in_data & ~grant_q & rlast_s;
    assign rlast_1  = in_data &  grant_q & rlast_s;

    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign len_err = len_err_q;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// tb/tb_sdram_rd_arbiter.sv - directed scoreboard bench for sdram_rd_arbiter
module tb_sdram_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr_0, araddr_1;
    logic [1:0]  arburst_0, arburst_1;
    logic        arvalid_0, arvalid_1;
    logic        arready_0, arready_1;
    logic [31:0] rdata_0, rdata_1;
    logic        rvalid_0, rvalid_1, rlast_0, rlast_1;
    logic [31:0] araddr_s;
    logic [1:0]  arburst_s;
    logic        arvalid_s, arready_s;
    logic [31:0] rdata_s;
    logic        rvalid_s, rlast_s;
    logic        grant, busy, len_err;

    sdram_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .araddr_0(araddr_0), .araddr_1(araddr_1),
        .arburst_0(arburst_0), .arburst_1(arburst_1),
        .arvalid_0(arvalid_0), .arvalid_1(arvalid_1),
        .arready_0(arready_0), .arready_1(arready_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rlast_0(rlast_0), .rlast_1(rlast_1),
        .araddr_s(araddr_s), .arburst_s(arburst_s),
        .arvalid_s(arvalid_s), .arready_s(arready_s),
        .rdata_s(rdata_s), .rvalid_s(rvalid_s), .rlast_s(rlast_s),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        m;
        logic        l;
        logic [31:0] d;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_len_err"}, len_err, 0);
        chk({tag, "_arvalid_s"}, arvalid_s, 0);
        chk({tag, "_arready"}, {arready_1, arready_0}, 0);
        chk({tag, "_rvalid"}, {rvalid_1, rvalid_0}, 0);
        chk({tag, "_rlast"}, {rlast_1, rlast_0}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_beat();
        beat_t e;
        chk("rvalid_onehot", {1'b0, rvalid_0} + {1'b0, rvalid_1}, 1);
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("beat_master", rvalid_1, e.m);
            chk("beat_data", e.m ? rdata_1 : rdata_0, e.d);
            chk("beat_rlast", e.m ? rlast_1 : rlast_0, e.l);
            chk("other_rlast", e.m ? rlast_0 : rlast_1, 0);
        end
    endtask

    // Acts as the shared slave: waits for the address, stalls, then returns nbeats.
    task automatic burst(input logic m, input logic [31:0] addr, input int stall,
                         input int nbeats, input bit last, input bit drop, output int wait_n);
        beat_t e;
        wait_n = 0;
        while (arvalid_s !== 1'b1 && wait_n < 40) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        chk("arvalid_s_rise", arvalid_s, 1);
        chk("araddr_s", araddr_s, addr);
        chk("grant", grant, m);
        chk("busy_addr", busy, 1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_arready", {arready_1, arready_0}, 0);
            @(negedge clk);
            #1;
            chk("stall_arvalid_s", arvalid_s, 1);
            chk("stall_araddr_s", araddr_s, addr);
        end
        arready_s = 1'b1;
        #1;
        chk("arready_grant", {arready_1, arready_0}, m ? 2'b10 : 2'b01);
        @(negedge clk);
        arready_s = 1'b0;
        if (drop) begin
            if (m) arvalid_1 = 1'b0;
            else   arvalid_0 = 1'b0;
        end
        #1;
        chk("arready_pulse", {arready_1, arready_0}, 0);
        chk("arvalid_s_data", arvalid_s, 0);
        for (int b = 0; b < nbeats; b++) begin
            rdata_s  = $urandom;
            rvalid_s = 1'b1;
            rlast_s  = last && (b == nbeats - 1);
            e.m = m;
            e.l = rlast_s;
            e.d = rdata_s;
            sb.push_back(e);
            #1;
            check_beat();
            @(negedge clk);
        end
        rvalid_s = 1'b0;
        rlast_s  = 1'b0;
        #1;
        chk("sb_empty", sb.size(), 0);
        if (last) chk("busy_after_last", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        araddr_0 = '0; araddr_1 = '0;
        arburst_0 = 2'b01; arburst_1 = 2'b01;
        arvalid_0 = 1'b0; arvalid_1 = 1'b0;
        arready_s = 1'b0; rdata_s = '0; rvalid_s = 1'b0; rlast_s = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single master
        araddr_0  = 32'h100;
        arvalid_0 = 1'b1;
        #1;
        burst(1'b0, 32'h100, 0, 32, 1'b1, 1'b1, n);
        chk("single_latency", n, 1);
        chk("single_len_err", len_err, 0);
        chk("single_grant", grant, 0);

        // Simultaneous, held continuously: 0,1,0 then 1
        araddr_0 = 32'h1000;
        araddr_1 = 32'h2000;
        arvalid_0 = 1'b1;
        arvalid_1 = 1'b1;
        do_reset();
        burst(1'b0, 32'h1000, 0, 32, 1'b1, 1'b0, n);
        chk("sim_first_latency", n, 1);
        burst(1'b1, 32'h2000, 0, 32, 1'b1, 1'b0, n);
        chk("sim_gap_1", n + 1, 2);
        burst(1'b0, 32'h1000, 0, 32, 1'b1, 1'b1, n);
        chk("sim_gap_2", n + 1, 2);
        burst(1'b1, 32'h2000, 0, 32, 1'b1, 1'b1, n);
        chk("sim_gap_3", n + 1, 2);
        chk("sim_len_err", len_err, 0);

        // Address backpressure
        araddr_0  = 32'h300;
        arvalid_0 = 1'b1;
        burst(1'b0, 32'h300, 5, 32, 1'b1, 1'b1, n);
        chk("bp_len_err", len_err, 0);

        // Short burst, then a normal one
        araddr_1  = 32'h400;
        arvalid_1 = 1'b1;
        burst(1'b1, 32'h400, 0, 31, 1'b1, 1'b1, n);
        chk("short_len_err", len_err, 1);
        araddr_0  = 32'h500;
        arvalid_0 = 1'b1;
        burst(1'b0, 32'h500, 0, 32, 1'b1, 1'b1, n);
        chk("short_sticky", len_err, 1);
        chk("short_next_grant", grant, 0);

        // Spurious data in IDLE
        do_reset();
        chk("spur_pre_len_err", len_err, 0);
        rdata_s  = 32'hdead_beef;
        rvalid_s = 1'b1;
        rlast_s  = 1'b1;
        #1;
        chk("spur_rvalid", {rvalid_1, rvalid_0}, 0);
        chk("spur_rlast", {rlast_1, rlast_0}, 0);
        @(negedge clk);
        rvalid_s = 1'b0;
        rlast_s  = 1'b0;
        #1;
        chk("spur_len_err", len_err, 1);
        chk("spur_busy", busy, 0);

        // Reset mid-burst: prio is left at 1 beforehand, so grant 0 proves it was reset
        do_reset();
        araddr_0  = 32'h600;
        arvalid_0 = 1'b1;
        burst(1'b0, 32'h600, 0, 32, 1'b1, 1'b1, n);
        arvalid_0 = 1'b1;
        burst(1'b0, 32'h600, 0, 10, 1'b0, 1'b1, n);
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        araddr_0  = 32'h700;
        araddr_1  = 32'h800;
        arvalid_0 = 1'b1;
        arvalid_1 = 1'b1;
        burst(1'b0, 32'h700, 0, 32, 1'b1, 1'b1, n);
        burst(1'b1, 32'h800, 0, 32, 1'b1, 1'b1, n);
        chk("mid_after_len_err", len_err, 0);
        chk("mid_after_grant", grant, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
